// File: rtl/c64_mem_pkg.sv
// Shared definitions for the C64 RAM controller: FSM state encoding,
// default geometry and the width of the CPU stall counter.
package c64_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/c64_ram_array.sv
// Single-port RAM array: synchronous write, asynchronous read on one shared
// address. A read of the address being written returns the old word.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : asynchronous read data, mem[addr]
module c64_ram_array
  import c64_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/c64_ram_ctrl.sv
// C64 RAM controller: clear engine after reset, then one array access per
// cycle arbitrated VIC over CPU.
//   clk, reset_n       : clock, asynchronous active-low reset
//   cpu_ab/do/we       : CPU address, write data, write enable
//   cpu_di, cpu_rdy    : CPU read data, access-performed (low = stall)
//   vic_req, vic_ab    : video read request and address
//   vic_data, vic_valid: video read data, valid one cycle after grant
//   busy               : clear engine active
//   stall_cnt          : saturating count of CPU stall cycles in RUN
module c64_ram_ctrl
  import c64_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       READ_LAT  = 0,
  parameter int unsigned       CLEAR_EN  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  cpu_ab,
  input  logic [DATA_W-1:0]  cpu_do,
  input  logic               cpu_we,
  output logic [DATA_W-1:0]  cpu_di,
  output logic               cpu_rdy,
  input  logic               vic_req,
  input  logic [ADDR_W-1:0]  vic_ab,
  output logic [DATA_W-1:0]  vic_data,
  output logic               vic_valid,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam state_e            RST_STATE = (CLEAR_EN != 0) ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [DATA_W-1:0]   vic_data_q, vic_data_d;
  logic                vic_valid_q, vic_valid_d;

  logic                run;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   rd_data;

  c64_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (rd_data)
  );

  // Gating with reset_n keeps the array untouched and the CPU stalled
  // while reset is held, even when the reset state is RUN.
  assign run     = (state_q == RUN);
  assign cpu_rdy = run & ~vic_req & reset_n;

  // Array port mux: clear engine, else VIC read, else CPU access.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = cpu_ab;
    arr_wdata = cpu_do;
    if (!run) begin
      arr_we    = reset_n;
      arr_addr  = cnt_q;
      arr_wdata = CLEAR_VAL;
    end else if (vic_req) begin
      arr_addr  = vic_ab;
    end else begin
      arr_we    = cpu_we & cpu_rdy;
    end
  end

  // Next-state: clear sweep, VIC capture, stall counting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    vic_data_d  = vic_data_q;
    vic_valid_d = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (vic_req) begin
          vic_valid_d = 1'b1;
          vic_data_d  = rd_data;
          if (stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      busy_q      <= (CLEAR_EN != 0);
      stall_q     <= '0;
      vic_data_q  <= '0;
      vic_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
      vic_data_q  <= vic_data_d;
      vic_valid_q <= vic_valid_d;
    end
  end

  assign busy      = busy_q;
  assign stall_cnt = stall_q;
  assign vic_data  = vic_data_q;
  assign vic_valid = vic_valid_q;

  // CPU read path: combinational, or registered and held over stalls/writes.
  if (READ_LAT == 0) begin : g_lat0
    assign cpu_di = (cpu_rdy && !cpu_we) ? rd_data : '0;
  end else begin : g_lat1
    logic [DATA_W-1:0] cpu_di_q, cpu_di_d;

    always_comb begin
      cpu_di_d = cpu_di_q;
      if (cpu_rdy && !cpu_we) begin
        cpu_di_d = rd_data;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cpu_di_q <= '0;
      end else begin
        cpu_di_q <= cpu_di_d;
      end
    end

    assign cpu_di = cpu_di_q;
  end

endmodule

// File: tb/tb_c64_ram_ctrl.sv
// Testbench for c64_ram_ctrl: three 16-word instances (combinational read,
// registered read, no clear engine) driven from shared CPU/VIC inputs.
module tb_c64_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rst2_n;
  logic [3:0] cpu_ab;
  logic [7:0] cpu_do;
  logic       cpu_we;
  logic       vic_req;
  logic [3:0] vic_ab;

  logic [7:0]  di0, di1, di2, vd0, vd1, vd2;
  logic        rdy0, rdy1, rdy2, vv0, vv1, vv2, busy0, busy1, busy2;
  logic [15:0] stall0, stall1, stall2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  c64_ram_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_LAT(0), .CLEAR_EN(1), .CLEAR_VAL(8'h00)) dut0 (
    .clk(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(di0), .cpu_rdy(rdy0), .vic_req(vic_req), .vic_ab(vic_ab),
    .vic_data(vd0), .vic_valid(vv0), .busy(busy0), .stall_cnt(stall0));

  c64_ram_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1), .CLEAR_EN(1), .CLEAR_VAL(8'h00)) dut1 (
    .clk(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(di1), .cpu_rdy(rdy1), .vic_req(vic_req), .vic_ab(vic_ab),
    .vic_data(vd1), .vic_valid(vv1), .busy(busy1), .stall_cnt(stall1));

  c64_ram_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_LAT(0), .CLEAR_EN(0), .CLEAR_VAL(8'h00)) dut2 (
    .clk(clk), .reset_n(rst2_n), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(di2), .cpu_rdy(rdy2), .vic_req(vic_req), .vic_ab(vic_ab),
    .vic_data(vd2), .vic_valid(vv2), .busy(busy2), .stall_cnt(stall2));

  typedef struct {
    logic        we;
    logic [3:0]  ab;
    logic [7:0]  wd;
    logic        vreq;
    logic [3:0]  vab;
    logic        rdy;    // dut0 cpu_rdy this cycle
    logic [7:0]  di0;    // dut0 cpu_di this cycle
    logic        vv;     // vic_valid after the edge
    logic [7:0]  vd;     // vic_data after the edge
    logic [7:0]  di1;    // dut1 cpu_di after the edge
    logic [15:0] stall;  // stall_cnt after the edge
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts busy cycles from the current sample point; pokes a CPU write and
  // a VIC request in the 10th cycle, both of which must be ignored.
  task automatic count_busy(output int n, output bit vseen);
    n = 0;
    vseen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy0) break;
      n++;
      cpu_we  = (n == 10);
      cpu_ab  = 4'h0;
      cpu_do  = 8'h77;
      vic_req = (n == 10);
      vic_ab  = 4'h5;
      @(posedge clk); #1;
      if (vv0) vseen = 1'b1;
      @(negedge clk); #1;
    end
    cpu_we  = 1'b0;
    vic_req = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      cpu_we = 1'b0;
      cpu_ab = 4'(a);
      #1;
      chk($sformatf("%s.mem%0d", tag, a), di0, 8'h00);
      @(posedge clk);
      @(negedge clk); #1;
    end
  endtask

  int nb;
  bit vs;

  initial begin
    tbl[0]  = '{1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[1]  = '{1'b1, 4'h3, 8'h5A, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[2]  = '{1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h5A, 16'd0};
    tbl[3]  = '{1'b1, 4'h7, 8'h33, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 16'd0};
    tbl[4]  = '{1'b1, 4'h7, 8'h11, 1'b1, 4'h3, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h5A, 16'd1};
    tbl[5]  = '{1'b0, 4'h7, 8'h00, 1'b0, 4'h0, 1'b1, 8'h33, 1'b0, 8'h5A, 8'h33, 16'd1};
    tbl[6]  = '{1'b0, 4'h3, 8'h00, 1'b1, 4'h7, 1'b0, 8'h00, 1'b1, 8'h33, 8'h33, 16'd2};
    tbl[7]  = '{1'b1, 4'hF, 8'hA5, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h33, 8'h33, 16'd2};
    tbl[8]  = '{1'b0, 4'hF, 8'h00, 1'b0, 4'h0, 1'b1, 8'hA5, 1'b0, 8'h33, 8'hA5, 16'd2};
    tbl[9]  = '{1'b1, 4'h0, 8'h01, 1'b0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h33, 8'hA5, 16'd2};
    tbl[10] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h01, 1'b0, 8'h33, 8'h01, 16'd2};
    tbl[11] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h00, 1'b1, 8'hA5, 8'h01, 16'd3};

    reset_n = 1'b0;
    rst2_n  = 1'b0;
    cpu_ab  = '0;
    cpu_do  = '0;
    cpu_we  = 1'b0;
    vic_req = 1'b0;
    vic_ab  = '0;

    // Reset values.
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst.busy0", busy0, 1'b1);
    chk("rst.rdy0", rdy0, 1'b0);
    chk("rst.di0", di0, 8'h00);
    chk("rst.di1", di1, 8'h00);
    chk("rst.vv0", vv0, 1'b0);
    chk("rst.vd0", vd0, 8'h00);
    chk("rst.stall0", stall0, 16'd0);
    chk("rst.busy2", busy2, 1'b0);
    chk("rst.rdy2", rdy2, 1'b0);

    // No-clear instance: CPU access on the first cycle after release.
    @(negedge clk);
    rst2_n = 1'b1;
    cpu_we = 1'b1;
    cpu_ab = 4'h2;
    cpu_do = 8'h42;
    #1;
    chk("noclr.busy2", busy2, 1'b0);
    chk("noclr.rdy2", rdy2, 1'b1);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk); #1;
    chk("noclr.rd2", di2, 8'h42);
    chk("noclr.rdy0_in_rst", rdy0, 1'b0);

    // First clear pass.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    count_busy(nb, vs);
    chk("clr1.busy_cycles", 32'(nb), 32'd16);
    chk("clr1.no_vic_valid", 32'(vs), 32'd0);
    chk("clr1.busy_end", busy0, 1'b0);
    chk("clr1.rdy_end", rdy0, 1'b1);
    chk("clr1.stall", stall0, 16'd0);
    read_all_zero("clr1");

    // Table-driven RUN vectors.
    for (int i = 0; i < 12; i++) begin
      cpu_we  = tbl[i].we;
      cpu_ab  = tbl[i].ab;
      cpu_do  = tbl[i].wd;
      vic_req = tbl[i].vreq;
      vic_ab  = tbl[i].vab;
      #1;
      chk($sformatf("tbl%0d.rdy", i), rdy0, tbl[i].rdy);
      chk($sformatf("tbl%0d.di0", i), di0, tbl[i].di0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.vv", i), vv0, tbl[i].vv);
      chk($sformatf("tbl%0d.vd", i), vd0, tbl[i].vd);
      chk($sformatf("tbl%0d.di1", i), di1, tbl[i].di1);
      chk($sformatf("tbl%0d.stall", i), stall0, tbl[i].stall);
      @(negedge clk); #1;
    end
    vic_req = 1'b0;

    // Fill the array with 8'hFF through the CPU port.
    for (int a = 0; a < 16; a++) begin
      cpu_we = 1'b1;
      cpu_ab = 4'(a);
      cpu_do = 8'hFF;
      @(posedge clk);
      @(negedge clk); #1;
    end
    cpu_we = 1'b0;

    // VIC grant, then reset while the next grant is in flight.
    vic_req = 1'b1;
    vic_ab  = 4'h3;
    @(posedge clk); #1;
    chk("vicrst.vv_pre", vv0, 1'b1);
    chk("vicrst.vd_pre", vd0, 8'hFF);
    chk("vicrst.stall_pre", stall0, 16'd4);
    vic_ab = 4'h5;
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("vicrst.vv_async", vv0, 1'b0);
    chk("vicrst.vd_async", vd0, 8'h00);
    chk("vicrst.di1_async", di1, 8'h00);
    chk("vicrst.stall_async", stall0, 16'd0);
    chk("vicrst.busy_async", busy0, 1'b1);
    @(posedge clk); #1;
    chk("vicrst.vv_post", vv0, 1'b0);
    vic_req = 1'b0;

    // Partial clear aborted at count 8 by a reset pulse.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort.busy_in_rst", busy0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    count_busy(nb, vs);
    chk("clr2.busy_cycles", 32'(nb), 32'd16);
    chk("clr2.no_vic_valid", 32'(vs), 32'd0);
    chk("clr2.rdy_end", rdy0, 1'b1);
    read_all_zero("clr2");

    // Stall counter saturation.
    vic_req = 1'b1;
    vic_ab  = 4'h0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat.stall0", stall0, 16'hFFFF);
    chk("sat.rdy0", rdy0, 1'b0);
    vic_req = 1'b0;
    @(negedge clk); #1;
    chk("sat.hold", stall0, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c64_ram_ctrl.md
C64_RAM_CTRL -- requirements
Module: c64_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, address width; memory depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 8, word width.
REQ-003 Parameter READ_LAT, default 0, CPU read latency; legal values are 0 (combinational) and 1 (registered).
REQ-004 Parameter CLEAR_EN, default 1; when 1, memory is cleared after reset.
REQ-005 Parameter CLEAR_VAL, default 0, DATA_W-bit fill word used by the clear engine.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cpu_ab  in  ADDR_W  CPU address.
REQ-009 cpu_do  in  DATA_W  CPU write data.
REQ-010 cpu_we  in  1  CPU write enable; high means write, low means read.
REQ-011 cpu_di  out  DATA_W  CPU read data.
REQ-012 cpu_rdy  out  1  CPU access performed this cycle; low means stall (6502 RDY).
REQ-013 vic_req  in  1  video read request (read-only port).
REQ-014 vic_ab  in  ADDR_W  video read address.
REQ-015 vic_data  out  DATA_W  video read data.
REQ-016 vic_valid  out  1  vic_data valid, one cycle after grant.
REQ-017 busy  out  1  clear engine active.
REQ-018 stall_cnt  out  16  saturating count of CPU stall cycles in RUN.

Function
REQ-019 FSM has two states, CLEAR and RUN; reset enters CLEAR if CLEAR_EN=1, otherwise RUN.
REQ-020 In CLEAR, an ADDR_W-bit counter writes CLEAR_VAL to address count each cycle, starting at 0 and ending at 2^ADDR_W-1.
REQ-021 In CLEAR: busy=1 and cpu_rdy=0; CPU writes are discarded; vic_req is ignored and vic_valid=0.
REQ-022 CLEAR moves to RUN on the cycle after the write to the all-ones address; the counter does not wrap back into a second pass.
REQ-023 In RUN, one array access occurs per cycle, with priority VIC over CPU.
REQ-024 In RUN with vic_req=1: VIC read is granted, cpu_rdy=0, and any CPU write that cycle is not performed.
REQ-025 In RUN with vic_req=0: cpu_rdy=1 and the CPU access is performed.
REQ-026 CPU writes in RUN with cpu_rdy=1 and cpu_we=1 update mem[cpu_ab] on that rising edge.
REQ-027 READ_LAT=0: cpu_di = mem[cpu_ab] combinationally when cpu_we=0 and cpu_rdy=1; otherwise cpu_di = 0.
REQ-028 READ_LAT=1: cpu_di is registered; it is mem[cpu_ab] as sampled in the cycle before, held when the previous cycle was a stall or a write.
REQ-029 A read of the address written in the same cycle returns the old data (read-before-write).
REQ-030 vic_data is registered mem[vic_ab] from the grant cycle; vic_valid=1 for exactly one cycle after each grant.
REQ-031 stall_cnt increments on each RUN cycle with cpu_rdy=0, saturates at 16'hFFFF, and does not count CLEAR cycles.

Reset
REQ-032 On reset_n=0, asynchronously: state=CLEAR (or RUN if CLEAR_EN=0), counter=0, busy=CLEAR_EN, cpu_rdy=0, cpu_di=0, vic_data=0, vic_valid=0, stall_cnt=0.
REQ-033 Reset does not alter array contents; only the clear engine does.
REQ-034 Reset asserted mid-CLEAR restarts the clear at address 0.
REQ-035 Reset asserted in RUN aborts any in-flight VIC read, with no vic_valid pulse.

Structure
REQ-036 Shared package c64_mem_pkg holds the FSM state enum (CLEAR, RUN), default widths and the stall counter width.
REQ-037 Storage is one sub-module, c64_ram_array: single-port, synchronous write, asynchronous read, parametrised by ADDR_W and DATA_W.
REQ-038 The arbiter, FSM, counters and read registers live in c64_ram_ctrl.

Verification
REQ-039 ADDR_W=4, preload array to 8'hFF, release reset -> busy=1 for 16 cycles, then all 16 words = 8'h00, busy=0, cpu_rdy=1.
REQ-040 RUN, CPU writes 8'h5A at 4'h3, then reads 4'h3 -> cpu_di=8'h5A same cycle (READ_LAT=0) or next cycle (READ_LAT=1).
REQ-041 vic_req=1 while CPU writes 8'h11 at 4'h7 -> cpu_rdy=0, mem[7] unchanged, vic_valid=1 next cycle with vic_data=mem[vic_ab], stall_cnt=1.
REQ-042 Reset pulsed at clear count 8 -> clear restarts at 0, busy=1 for a further 16 cycles.
REQ-043 vic_req held high for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
REQ-044 CLEAR_EN=0 -> busy=0 and CPU access is possible on the first cycle after reset release.
